fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among `N_REQ` requesters. It grants one requester per cycle and supports packet lock: a multi-beat packet keeps the grant until its last beat. It replaces the FIFO's `full` flag with an internal credit counter, so the FIFO is never written while full. It sits directly in front of the FIFO's `wr_en`/`wr_data` and is reset together with it.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: data width; must match the FIFO `WIDTH`.
- `DEPTH`, 16: FIFO depth; initial and maximum credit count.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: requester i has a beat.
- `req_last` in N_REQ: beat from requester i is the last of its packet.
- `req_data` in N_REQ*WIDTH: beat data; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready` out N_REQ: combinational grant. At most one bit is set.
- `fifo_wr_en` out 1: registered write strobe to the FIFO.
- `fifo_wr_data` out WIDTH: registered write data.
- `fifo_wr_src` out $clog2(N_REQ): index of the source of the current write.
- `fifo_rd_fire` in 1: pulse when the consumer pops one entry (FIFO `rd_en` & !`empty`).
- `credits` out $clog2(DEPTH)+1: free FIFO slots as tracked by the arbiter.
- `credit_err` out 1: sticky flag, set when `fifo_rd_fire` arrives while `credits`==DEPTH.

## Operation
- Accept for requester i occurs when `req_valid[i] & req_ready[i]`.
- State IDLE:
  - If `credits`>0, pick the first i with `req_valid[i]`. The search starts at (`rr_ptr`+1) mod N_REQ and wraps. Assert `req_ready[i]`.
  - On accept, set `rr_ptr`<=i.
  - If `req_last[i]`=0, go to LOCKED(i) and store `lock_id`<=i.
  - If `req_last[i]`=1, stay in IDLE.
- State LOCKED:
  - `req_ready[lock_id]` = `credits`>0. All other `req_ready` bits are 0, even if those requesters are valid.
  - An accept with `req_last`=1 returns the FSM to IDLE.
  - A dropped `req_valid` holds the lock; there is no timeout.
- Credits:
  - An accept decrements `credits`.
  - `fifo_rd_fire` increments `credits`.
  - Both in the same cycle leave `credits` unchanged.
  - `credits`==0: all `req_ready` are 0 and no accept occurs.
  - `fifo_rd_fire` while `credits`==DEPTH without a same-cycle accept: `credits` holds at DEPTH and `credit_err`<=1. `credit_err` clears only on `rst`.
- Write port:
  - `fifo_wr_en`<=accept.
  - On accept, `fifo_wr_data`<=winner data and `fifo_wr_src`<=winner.
  - With no accept, data and src hold their last values.
- Arithmetic: `rr_ptr` and `lock_id` wrap modulo N_REQ. `credits` saturates at 0 and DEPTH and never wraps.

## Timing
- Reset values:
  - `req_ready`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `fifo_wr_src`=0.
  - `credits`=DEPTH, `credit_err`=0.
  - State IDLE, `rr_ptr`=N_REQ-1, so requester 0 has first priority.
  - During `rst`=1, `req_ready`=0.
- `req_ready` is a function of registered state plus `req_valid`, valid in the same cycle. There is no bubble between back-to-back accepts.
- Latency: a beat accepted in cycle n appears on `fifo_wr_en`/`fifo_wr_data` in cycle n+1. The FIFO stores it at the n+1→n+2 edge.
- Throughput is one beat per cycle while `credits`>0.
- `credits` updates on the edge after the accept or `fifo_rd_fire`. Credit return therefore lags the pop by one cycle; this is conservative and the FIFO never overflows.
- Reset mid-packet drops the lock and restores full credits. Beats already written stay in the FIFO. `rst` must reset the FIFO in the same cycle.

## Test plan
- Reset, then `req_valid`=4'b1111 with `req_last`=1111 and `credits` ample → grants in order 0,1,2,3,0. Each `fifo_wr_en` is one cycle later and `fifo_wr_src` matches.
- Requester 2 sends a 3-beat packet (`req_last` only on beat 3) while requesters 0, 1 and 3 are valid → three consecutive writes with `fifo_wr_src`=2, then a grant to 3.
- No `fifo_rd_fire`, all requesters valid → exactly 16 accepts. Then `credits`=0 and `req_ready`=0. One `fifo_rd_fire` → `credits`=1 and one more accept.
- `credits`=0 with an accept and `fifo_rd_fire` in the same cycle later → `credits` unchanged across the cycle. `fifo_rd_fire` with `credits`=16 → `credit_err`=1, `credits`=16.
- `rst` pulsed on beat 2 of a locked 4-beat packet from requester 1 → next cycle IDLE, `credits`=16, `credit_err`=0. A valid requester 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with packet lock and credit-based flow control
// in front of the single write port of a synchronous FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0]   fifo_wr_src,
    input  logic                       fifo_rd_fire,
    output logic [$clog2(DEPTH):0]     credits,
    output logic                       credit_err
);

    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned CRED_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   lock_id;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic               grant_ok;
    logic               accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection: locked owner, else first valid after the last winner
    always_comb begin
        next_state = state;
        grant_idx  = '0;
        grant_ok   = 1'b0;
        cand       = '0;
        req_ready  = '0;
        accept     = 1'b0;
        if (!rst && credits != '0) begin
            if (state == LOCKED) begin
                grant_idx = lock_id;
                grant_ok  = 1'b1;
            end else begin
                for (int unsigned k = 1; k <= N_REQ; k++) begin
                    cand = PTR_W'((32'(rr_ptr) + k) % N_REQ);
                    if (!grant_ok && req_valid[cand]) begin
                        grant_idx = cand;
                        grant_ok  = 1'b1;
                    end
                end
            end
        end
        if (grant_ok) begin
            req_ready[grant_idx] = 1'b1;
        end
        accept = grant_ok & req_valid[grant_idx];
        if (accept) begin
            next_state = req_last[grant_idx] ? IDLE : LOCKED;
        end
    end

    // Write port and arbitration pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= PTR_W'(N_REQ - 1);
            lock_id      <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_wr_src  <= '0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                rr_ptr       <= grant_idx;
                lock_id      <= grant_idx;
                fifo_wr_data <= req_data[grant_idx*WIDTH +: WIDTH];
                fifo_wr_src  <= grant_idx;
            end
        end
    end

    // Credit counter; an accept implies credits > 0, so only the top needs guarding
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CRED_W'(DEPTH);
            credit_err <= 1'b0;
        end else if (accept && !fifo_rd_fire) begin
            credits <= credits - CRED_W'(1);
        end else if (fifo_rd_fire && !accept) begin
            if (credits == CRED_W'(DEPTH)) begin
                credit_err <= 1'b1;
            end else begin
                credits <= credits + CRED_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned PW = 2;
    localparam int unsigned CW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_wr_data;
    logic [PW-1:0]   fifo_wr_src;
    logic            fifo_rd_fire;
    logic [CW-1:0]   credits;
    logic            credit_err;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_src  (fifo_wr_src),
        .fifo_rd_fire (fifo_rd_fire),
        .credits      (credits),
        .credit_err   (credit_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: free slots, last winner, packet owner
    int          m_credits = D;
    int          m_prev    = N - 1;
    int          m_owner   = 0;
    bit          m_locked  = 1'b0;
    bit          m_err     = 1'b0;
    bit          m_wr_en   = 1'b0;
    int          m_src     = 0;
    logic [W-1:0] m_data   = '0;

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [3:0] rdy;
        logic       wr;
        int         src;
        int         cred;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        if (rst || m_credits == 0) return -1;
        if (m_locked) return m_owner;
        for (int k = 1; k <= int'(N); k++) begin
            int j = (m_prev + k) % int'(N);
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    // One cycle: drive, check grant, advance model, check registered outputs
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic f, output logic [N-1:0] rdy_seen);
        int w;
        bit acc;
        rst          = r;
        req_valid    = v;
        req_last     = l;
        fifo_rd_fire = f;
        req_data     = (N*W)'($urandom());
        #1;
        rdy_seen = req_ready;
        w = model_winner();
        check("req_ready", int'(req_ready), (w < 0) ? 0 : (1 << w));
        acc = (w >= 0) && req_valid[w];
        if (r) begin
            m_credits = D; m_err = 1'b0; m_locked = 1'b0; m_prev = N - 1;
            m_wr_en = 1'b0; m_src = 0; m_data = '0;
        end else begin
            if (acc && !f) m_credits--;
            else if (f && !acc) begin
                if (m_credits == int'(D)) m_err = 1'b1;
                else m_credits++;
            end
            m_wr_en = acc;
            if (acc) begin
                m_src    = w;
                m_data   = req_data[w*W +: W];
                m_prev   = w;
                m_owner  = w;
                m_locked = !req_last[w];
            end
        end
        @(posedge clk);
        #1;
        check("fifo_wr_en",   int'(fifo_wr_en),   int'(m_wr_en));
        check("fifo_wr_data", int'(fifo_wr_data), int'(m_data));
        check("fifo_wr_src",  int'(fifo_wr_src),  m_src);
        check("credits",      int'(credits),      m_credits);
        check("credit_err",   int'(credit_err),   int'(m_err));
    endtask

    initial begin
        logic [N-1:0] rdy;
        int           cnt;

        // Reset, round robin 0,1,2,3,0, then a locked 3-beat packet from 2
        tbl[0] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 0, 16};
        tbl[1] = '{1'b0, 4'hf, 4'hf, 1'b0, 4'h1, 1'b1, 0, 15};
        tbl[2] = '{1'b0, 4'hf, 4'hf, 1'b0, 4'h2, 1'b1, 1, 14};
        tbl[3] = '{1'b0, 4'hf, 4'hf, 1'b0, 4'h4, 1'b1, 2, 13};
        tbl[4] = '{1'b0, 4'hf, 4'hf, 1'b0, 4'h8, 1'b1, 3, 12};
        tbl[5] = '{1'b0, 4'hf, 4'hf, 1'b0, 4'h1, 1'b1, 0, 11};
        tbl[6] = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h4, 1'b1, 2, 10};
        tbl[7] = '{1'b0, 4'hf, 4'h0, 1'b0, 4'h4, 1'b1, 2, 9};
        tbl[8] = '{1'b0, 4'hf, 4'h4, 1'b0, 4'h4, 1'b1, 2, 8};
        tbl[9] = '{1'b0, 4'hb, 4'hf, 1'b0, 4'h8, 1'b1, 3, 7};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f, rdy);
            check("tbl_ready",   int'(rdy),        int'(tbl[i].rdy));
            check("tbl_wr_en",   int'(fifo_wr_en), int'(tbl[i].wr));
            check("tbl_wr_src",  int'(fifo_wr_src), tbl[i].src);
            check("tbl_credits", int'(credits),    tbl[i].cred);
        end

        // Credit exhaustion: exactly DEPTH accepts without any pop
        step(1'b1, '0, '0, 1'b0, rdy);
        cnt = 0;
        for (int i = 0; i < int'(D) + 3; i++) begin
            step(1'b0, '1, '1, 1'b0, rdy);
            cnt += int'(fifo_wr_en);
        end
        check("accepts_to_empty", cnt, 16);
        check("credits_zero", int'(credits), 0);
        check("ready_at_zero", int'(rdy), 0);
        step(1'b0, '1, '1, 1'b1, rdy);
        check("pop_at_zero_ready", int'(rdy), 0);
        check("pop_at_zero_credits", int'(credits), 1);
        step(1'b0, '1, '1, 1'b1, rdy);
        check("accept_and_pop_wr", int'(fifo_wr_en), 1);
        check("accept_and_pop_credits", int'(credits), 1);
        step(1'b0, '1, '1, 1'b0, rdy);
        check("last_credit_used", int'(credits), 0);

        // Pop at full credit: tolerated with a same-cycle accept, error otherwise
        step(1'b1, '0, '0, 1'b0, rdy);
        step(1'b0, '1, '1, 1'b1, rdy);
        check("full_pop_with_accept_err", int'(credit_err), 0);
        check("full_pop_with_accept_cred", int'(credits), 16);
        step(1'b0, '0, '0, 1'b1, rdy);
        check("overflow_err", int'(credit_err), 1);
        check("overflow_credits", int'(credits), 16);
        step(1'b0, '0, '0, 1'b0, rdy);
        check("err_sticky", int'(credit_err), 1);

        // Reset mid-packet drops the lock and clears the error
        step(1'b0, 4'b0010, 4'b0000, 1'b0, rdy);
        check("lock_beat1_src", int'(fifo_wr_src), 1);
        step(1'b1, 4'b0010, 4'b0000, 1'b0, rdy);
        check("rst_ready", int'(rdy), 0);
        check("rst_credits", int'(credits), 16);
        check("rst_err", int'(credit_err), 0);
        check("rst_wr_en", int'(fifo_wr_en), 0);
        step(1'b0, 4'b0011, 4'b1111, 1'b0, rdy);
        check("post_rst_ready", int'(rdy), 1);
        check("post_rst_src", int'(fifo_wr_src), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(299) == 0),
                 N'($urandom()),
                 N'($urandom() | $urandom()),
                 ($urandom_range(9) < 3),
                 rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
